// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and spi_master-side signal bundle for spi_bus_arbiter.
// Requests are level signals held until that port's done pulse; done/err are one-cycle pulses.
interface spi_bus_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int NB_W   = 3
);
    logic [1:0]             req_rd;
    logic [1:0]             req_wr;
    logic [1:0][ADDR_W-1:0] req_addr;
    logic [1:0][NB_W-1:0]   req_nb;
    logic [1:0][7:0]        req_wdata;
    logic [1:0]             gnt;
    logic [1:0]             done;
    logic [1:0]             err;
    logic [1:0]             byte_done_o;
    logic [7:0]             rdata;
    logic                   m_start_read;
    logic                   m_start_write;
    logic [ADDR_W-1:0]      m_addr;
    logic [NB_W-1:0]        m_nb;
    logic [7:0]             m_wdata;
    logic [7:0]             m_read_data;
    logic                   m_busy;
    logic                   m_byte_done;
    logic                   m_xfer_done;

    modport slave (
        input  req_rd, req_wr, req_addr, req_nb, req_wdata,
        input  m_read_data, m_busy, m_byte_done, m_xfer_done,
        output gnt, done, err, byte_done_o, rdata,
        output m_start_read, m_start_write, m_addr, m_nb, m_wdata
    );

    modport master (
        output req_rd, req_wr, req_addr, req_nb, req_wdata,
        output m_read_data, m_busy, m_byte_done, m_xfer_done,
        input  gnt, done, err, byte_done_o, rdata,
        input  m_start_read, m_start_write, m_addr, m_nb, m_wdata
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Two-port arbiter sharing one spi_master: grant, start pulse, byte/done routing, release.
// Define SPI_ARB_FIXED_PRIO_EN to make port 0 win every contest instead of round-robin.
module spi_bus_arbiter #(
    parameter int ADDR_W = 16,
    parameter int NB_W   = 3
) (
    input  logic                clk,
    input  logic                rst,
    spi_bus_arbiter_if.slave    bus,
    output logic [1:0]          o_dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_gnt;
    logic              r_cur;
    logic              r_last;
    logic              r_op_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [NB_W-1:0]   r_nb;
    logic [NB_W-1:0]   r_byte_cnt;
    logic [1:0]        r_done;
    logic [1:0]        r_err;

    logic [1:0]        w_act;
    logic              w_win;
    logic [1:0]        w_win_oh;
    logic              w_launch;
    logic              w_zero;
    logic [NB_W-1:0]   w_cnt_next;

    assign w_act = bus.req_rd | bus.req_wr;

    always_comb begin
        w_win = ~w_act[0];
`ifndef SPI_ARB_FIXED_PRIO_EN
        if (&w_act) begin
            w_win = ~r_last;
        end
`endif
    end

    assign w_win_oh   = w_win ? 2'b10 : 2'b01;
    assign w_launch   = (r_state == S_IDLE) && (|w_act) && !bus.m_busy;
    assign w_zero     = (bus.req_nb[w_win] == '0);
    // A byte arriving together with transfer_done is counted before the compare.
    assign w_cnt_next = r_byte_cnt + {{(NB_W-1){1'b0}}, bus.m_byte_done};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (w_launch) w_state_next = w_zero ? S_RELEASE : S_ISSUE;
            S_ISSUE:   w_state_next = S_WAIT;
            S_WAIT:    if (bus.m_xfer_done) w_state_next = S_RELEASE;
            S_RELEASE: w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt      <= '0;
            r_cur      <= 1'b0;
            r_last     <= 1'b1;
            r_op_wr    <= 1'b0;
            r_addr     <= '0;
            r_nb       <= '0;
            r_byte_cnt <= '0;
            r_done     <= '0;
            r_err      <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_launch) begin
                        r_cur   <= w_win;
                        // Writeback goes before refill when a port asks for both.
                        r_op_wr <= bus.req_wr[w_win];
                        if (w_zero) begin
                            r_done <= w_win_oh;
                        end else begin
                            r_gnt  <= w_win_oh;
                            r_addr <= bus.req_addr[w_win];
                            r_nb   <= bus.req_nb[w_win];
                        end
                    end
                end
                S_ISSUE: r_byte_cnt <= '0;
                S_WAIT: begin
                    r_byte_cnt <= w_cnt_next;
                    if (bus.m_xfer_done) begin
                        r_done <= r_gnt;
                        r_err  <= (w_cnt_next != r_nb) ? r_gnt : 2'b00;
                        r_gnt  <= '0;
                    end
                end
                S_RELEASE: r_last <= r_cur;
                default: ;
            endcase
        end
    end

    assign bus.gnt           = r_gnt;
    assign bus.done          = r_done;
    assign bus.err           = r_err;
    assign bus.byte_done_o   = (r_state == S_WAIT) ? (r_gnt & {2{bus.m_byte_done}}) : 2'b00;
    assign bus.rdata         = bus.m_read_data;
    assign bus.m_start_read  = (r_state == S_ISSUE) && !r_op_wr;
    assign bus.m_start_write = (r_state == S_ISSUE) && r_op_wr;
    assign bus.m_addr        = r_addr;
    assign bus.m_nb          = r_nb;
    assign bus.m_wdata       = r_gnt[1] ? bus.req_wdata[1] : (r_gnt[0] ? bus.req_wdata[0] : 8'h00);
    assign o_dbg_state       = r_state;
endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed self-checking bench for spi_bus_arbiter with a simple spi_master stand-in.
module tb_spi_bus_arbiter;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_chk;
    int         n_pass;
    int         hits;
    int         cyc;

    spi_bus_arbiter_if #(.ADDR_W(16), .NB_W(3)) bus ();

    spi_bus_arbiter #(.ADDR_W(16), .NB_W(3)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_rd = '0;
        bus.req_wr = '0;
        bus.req_addr = '0;
        bus.req_nb = '0;
        bus.req_wdata = '0;
        bus.m_read_data = '0;
        bus.m_busy = 1'b0;
        bus.m_byte_done = 1'b0;
        bus.m_xfer_done = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    // spi_master stand-in: n byte_done pulses, counts cycles where routing matched port_oh
    task automatic master_bytes(input int n, input logic [1:0] port_oh, output int h);
        h = 0;
        for (int i = 0; i < n; i++) begin
            bus.m_byte_done = 1'b1;
            bus.m_read_data = 8'h10 + 8'(i);
            #1;
            if (bus.byte_done_o === port_oh) h++;
            tick();
        end
        bus.m_byte_done = 1'b0;
    endtask

    task automatic master_xfer_done();
        bus.m_xfer_done = 1'b1;
        tick();
        bus.m_xfer_done = 1'b0;
    endtask

    task automatic wait_gnt(output int c);
        c = -1;
        for (int i = 0; i < 10; i++) begin
            if (bus.gnt !== 2'b00) begin
                c = i;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (bus.gnt !== 2'b00) $display("FAIL reset_gnt got %b exp 00", bus.gnt); else n_pass++;
        n_chk++; if (bus.done !== 2'b00 || bus.err !== 2'b00) $display("FAIL reset_done_err got %b/%b exp 00/00", bus.done, bus.err); else n_pass++;
        n_chk++; if ({bus.m_start_read, bus.m_start_write} !== 2'b00) $display("FAIL reset_start got %b exp 00", {bus.m_start_read, bus.m_start_write}); else n_pass++;
        n_chk++; if (bus.m_addr !== 16'h0000 || bus.m_nb !== 3'd0) $display("FAIL reset_addr_nb got %h/%0d exp 0000/0", bus.m_addr, bus.m_nb); else n_pass++;
        n_chk++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d exp 0", dbg_state); else n_pass++;
    endtask

    task automatic test_single_read();
        bus.req_rd[0] = 1'b1;
        bus.req_addr[0] = 16'h0100;
        bus.req_nb[0] = 3'd5;
        tick();
        n_chk++; if (bus.gnt !== 2'b01) $display("FAIL rd_gnt got %b exp 01", bus.gnt); else n_pass++;
        n_chk++; if ({bus.m_start_read, bus.m_start_write} !== 2'b10) $display("FAIL rd_start got %b exp 10", {bus.m_start_read, bus.m_start_write}); else n_pass++;
        n_chk++; if (bus.m_addr !== 16'h0100 || bus.m_nb !== 3'd5) $display("FAIL rd_addr_nb got %h/%0d exp 0100/5", bus.m_addr, bus.m_nb); else n_pass++;
        tick();
        n_chk++; if (bus.m_start_read !== 1'b0) $display("FAIL rd_start_len got %b exp 0", bus.m_start_read); else n_pass++;
        bus.m_read_data = 8'h5A;
        #1;
        n_chk++; if (bus.rdata !== 8'h5A) $display("FAIL rd_rdata got %h exp 5a", bus.rdata); else n_pass++;
        master_bytes(5, 2'b01, hits);
        n_chk++; if (hits !== 5) $display("FAIL rd_byte_route got %0d exp 5", hits); else n_pass++;
        n_chk++; if (bus.done !== 2'b00) $display("FAIL rd_done_early got %b exp 00", bus.done); else n_pass++;
        master_xfer_done();
        n_chk++; if (bus.done !== 2'b01 || bus.err !== 2'b00) $display("FAIL rd_done_err got %b/%b exp 01/00", bus.done, bus.err); else n_pass++;
        n_chk++; if (bus.gnt !== 2'b00) $display("FAIL rd_release_gnt got %b exp 00", bus.gnt); else n_pass++;
        bus.req_rd[0] = 1'b0;
        tick();
        n_chk++; if (bus.done !== 2'b00 || dbg_state !== 2'd0) $display("FAIL rd_after got %b/%0d exp 00/0", bus.done, dbg_state); else n_pass++;
    endtask

    task automatic test_two_writers();
        do_reset();
        bus.req_wr = 2'b11;
        bus.req_addr[0] = 16'h0010; bus.req_nb[0] = 3'd1; bus.req_wdata[0] = 8'hAA;
        bus.req_addr[1] = 16'h0020; bus.req_nb[1] = 3'd2; bus.req_wdata[1] = 8'h55;
        tick();
        n_chk++; if (bus.gnt !== 2'b01 || bus.m_start_write !== 1'b1) $display("FAIL wr0_gnt got %b/%b exp 01/1", bus.gnt, bus.m_start_write); else n_pass++;
        n_chk++; if (bus.m_wdata !== 8'hAA) $display("FAIL wr0_wdata got %h exp aa", bus.m_wdata); else n_pass++;
        bus.req_wdata[0] = 8'h33;
        bus.req_addr[0] = 16'hFFFF;
        #1;
        n_chk++; if (bus.m_wdata !== 8'h33 || bus.m_addr !== 16'h0010) $display("FAIL wr0_follow got %h/%h exp 33/0010", bus.m_wdata, bus.m_addr); else n_pass++;
        tick();
        master_bytes(1, 2'b01, hits);
        master_xfer_done();
        n_chk++; if (bus.done !== 2'b01 || bus.err !== 2'b00) $display("FAIL wr0_done got %b/%b exp 01/00", bus.done, bus.err); else n_pass++;
        bus.req_wr[0] = 1'b0;
        wait_gnt(cyc);
        n_chk++; if (cyc !== 2) $display("FAIL wr1_gnt_latency got %0d exp 2", cyc); else n_pass++;
        n_chk++; if (bus.gnt !== 2'b10 || bus.m_addr !== 16'h0020 || bus.m_wdata !== 8'h55) $display("FAIL wr1_gnt got %b/%h/%h exp 10/0020/55", bus.gnt, bus.m_addr, bus.m_wdata); else n_pass++;
        tick();
        master_bytes(2, 2'b10, hits);
        n_chk++; if (hits !== 2) $display("FAIL wr1_byte_route got %0d exp 2", hits); else n_pass++;
        master_xfer_done();
        n_chk++; if (bus.done !== 2'b10 || bus.err !== 2'b00) $display("FAIL wr1_done got %b/%b exp 10/00", bus.done, bus.err); else n_pass++;
        bus.req_wr[1] = 1'b0;
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_g[4];
`ifdef SPI_ARB_FIXED_PRIO_EN
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
        do_reset();
        bus.req_rd = 2'b11;
        bus.req_nb[0] = 3'd1;
        bus.req_nb[1] = 3'd1;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(cyc);
            n_chk++; if (bus.gnt !== exp_g[k]) $display("FAIL rr_gnt%0d got %b exp %b", k, bus.gnt, exp_g[k]); else n_pass++;
            tick();
            master_bytes(1, exp_g[k], hits);
            master_xfer_done();
            n_chk++; if (bus.done !== exp_g[k]) $display("FAIL rr_done%0d got %b exp %b", k, bus.done, exp_g[k]); else n_pass++;
        end
        bus.req_rd = 2'b00;
        repeat (2) tick();
    endtask

    task automatic test_zero_nb();
        bus.req_rd[1] = 1'b1;
        bus.req_nb[1] = 3'd0;
        tick();
        n_chk++; if (bus.done !== 2'b10 || bus.err !== 2'b00) $display("FAIL nb0_done got %b/%b exp 10/00", bus.done, bus.err); else n_pass++;
        n_chk++; if (bus.gnt !== 2'b00 || {bus.m_start_read, bus.m_start_write} !== 2'b00) $display("FAIL nb0_nostart got %b/%b exp 00/00", bus.gnt, {bus.m_start_read, bus.m_start_write}); else n_pass++;
        bus.req_rd[1] = 1'b0;
        tick();
        n_chk++; if (bus.done !== 2'b00 || {bus.m_start_read, bus.m_start_write} !== 2'b00) $display("FAIL nb0_after got %b/%b exp 00/00", bus.done, {bus.m_start_read, bus.m_start_write}); else n_pass++;
    endtask

    task automatic test_short_count();
        bus.req_rd[0] = 1'b1;
        bus.req_addr[0] = 16'h0200;
        bus.req_nb[0] = 3'd5;
        tick();
        n_chk++; if (bus.gnt !== 2'b01) $display("FAIL short_gnt got %b exp 01", bus.gnt); else n_pass++;
        bus.req_rd[0] = 1'b0;
        tick();
        master_bytes(4, 2'b01, hits);
        master_xfer_done();
        n_chk++; if (bus.done !== 2'b01 || bus.err !== 2'b01) $display("FAIL short_err got %b/%b exp 01/01", bus.done, bus.err); else n_pass++;
        tick();
        n_chk++; if (bus.err !== 2'b00) $display("FAIL short_err_len got %b exp 00", bus.err); else n_pass++;
    endtask

    task automatic test_same_cycle();
        bus.req_wr[1] = 1'b1;
        bus.req_nb[1] = 3'd2;
        tick();
        n_chk++; if (bus.gnt !== 2'b10) $display("FAIL same_gnt got %b exp 10", bus.gnt); else n_pass++;
        tick();
        master_bytes(1, 2'b10, hits);
        bus.m_byte_done = 1'b1;
        bus.m_xfer_done = 1'b1;
        #1;
        n_chk++; if (bus.byte_done_o !== 2'b10) $display("FAIL same_route got %b exp 10", bus.byte_done_o); else n_pass++;
        tick();
        bus.m_byte_done = 1'b0;
        bus.m_xfer_done = 1'b0;
        n_chk++; if (bus.done !== 2'b10 || bus.err !== 2'b00) $display("FAIL same_done got %b/%b exp 10/00", bus.done, bus.err); else n_pass++;
        bus.req_wr[1] = 1'b0;
        tick();
    endtask

    task automatic test_busy_rw();
        bus.m_busy = 1'b1;
        bus.req_rd[0] = 1'b1;
        bus.req_wr[0] = 1'b1;
        bus.req_nb[0] = 3'd1;
        tick();
        n_chk++; if (bus.gnt !== 2'b00 || dbg_state !== 2'd0) $display("FAIL busy_hold got %b/%0d exp 00/0", bus.gnt, dbg_state); else n_pass++;
        bus.m_busy = 1'b0;
        tick();
        n_chk++; if (bus.gnt !== 2'b01 || {bus.m_start_read, bus.m_start_write} !== 2'b01) $display("FAIL rw_prefers_wr got %b/%b exp 01/01", bus.gnt, {bus.m_start_read, bus.m_start_write}); else n_pass++;
        tick();
        master_bytes(1, 2'b01, hits);
        master_xfer_done();
        n_chk++; if (bus.done !== 2'b01) $display("FAIL rw_done got %b exp 01", bus.done); else n_pass++;
        bus.req_rd[0] = 1'b0;
        bus.req_wr[0] = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        bus.req_rd[0] = 1'b1;
        bus.req_addr[0] = 16'h0300;
        bus.req_nb[0] = 3'd5;
        tick();
        tick();
        master_bytes(2, 2'b01, hits);
        rst = 1'b1;
        #1;
        n_chk++; if (bus.gnt !== 2'b00 || dbg_state !== 2'd0 || bus.m_addr !== 16'h0000) $display("FAIL rstmid_clear got %b/%0d/%h exp 00/0/0000", bus.gnt, dbg_state, bus.m_addr); else n_pass++;
        tick();
        n_chk++; if (bus.done !== 2'b00) $display("FAIL rstmid_nodone got %b exp 00", bus.done); else n_pass++;
        rst = 1'b0;
        tick();
        n_chk++; if (bus.gnt !== 2'b01 || bus.m_start_read !== 1'b1 || bus.m_addr !== 16'h0300) $display("FAIL rstmid_restart got %b/%b/%h exp 01/1/0300", bus.gnt, bus.m_start_read, bus.m_addr); else n_pass++;
        tick();
        master_bytes(5, 2'b01, hits);
        master_xfer_done();
        n_chk++; if (bus.done !== 2'b01 || bus.err !== 2'b00) $display("FAIL rstmid_done got %b/%b exp 01/00", bus.done, bus.err); else n_pass++;
        bus.req_rd[0] = 1'b0;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_single_read();
        test_two_writers();
        test_round_robin();
        test_zero_nb();
        test_short_count();
        test_same_cycle();
        test_busy_rw();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish exp finish before 200000");
        $fatal(1);
    end
endmodule
